dxl_packet_framer: RTL
======================

# dxl_packet_framer

Builds Dynamixel Protocol 2.0 instruction packets for the XL320 half-duplex bus. Sits directly downstream of the XL320 Avalon command decoder. It takes one decoded command per handshake: motor id, instruction, register, value and byte count. It then streams the framed packet byte by byte, with header, length, parameters and CRC-16, into the UART transmitter that drives `serial_io`.

## Interface
Parameters: none.
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  framer idle, command accepted on `cmd_valid && cmd_ready`
- `cmd_id`  in  8  motor id (0xFE broadcast passes unchanged)
- `cmd_inst`  in  8  instruction code (PING 0x01, READ 0x02, WRITE 0x03, REG_WRITE 0x04, ACTION 0x05, REBOOT 0x08, ...)
- `cmd_addr`  in  16  control-table address
- `cmd_data`  in  32  write value, LSB first on the wire
- `cmd_len`  in  3  data byte count (WRITE/REG_WRITE) or read length (READ)
- `tx_data`  out  8  packet byte
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  UART accepts byte
- `tx_last`  out  1  marks CRC_H byte
- `busy`  out  1  packet in progress (not IDLE)

## Operation
- Wire format: FF FF FD 00, ID, LEN_L, LEN_H, INST, PARAMS, CRC_L, CRC_H.
- LEN is the number of parameter bytes + 3.
- Params by instruction:
  - WRITE/REG_WRITE: addr_L, addr_H, then min(cmd_len,4) bytes of `cmd_data`.
  - READ: addr_L, addr_H, cmd_len (zero-extended, 16-bit LE).
  - All other codes: no params.
- CRC-16: polynomial 0x8005, init 0x0000, no reflection, no final XOR. Covers every byte from the first FF through the last param, stuffed bytes included. Updated on each accepted byte.
- States: IDLE → LOAD → HDR (4 bytes, index counter) → ID → LEN_L → LEN_H → PAYLOAD (index counter over buffered INST+params) → CRC_L → CRC_H → IDLE.
- LOAD latches command fields into a payload buffer and computes LEN. It lasts exactly one cycle and ignores `tx_ready`.
- Every non-IDLE/LOAD state advances only on `tx_valid && tx_ready`.
- Command inputs are ignored while busy. Only the latched copy is used.

## Timing
- Reset values: `cmd_ready`=0 while reset is asserted and 1 after release (IDLE). `tx_valid`=0, `tx_data`=0x00, `tx_last`=0, `busy`=0, CRC=0.
- Command accepted at edge N: LOAD is active in cycle N+1, and the first FF is presented with `tx_valid`=1 in cycle N+2.
- With `tx_ready` held high, one byte transfers per cycle, so a packet of L bytes completes L+1 cycles after acceptance.
- `tx_data`/`tx_last` are held stable while `tx_valid && !tx_ready`. `tx_valid` never drops before a transfer.
- `cmd_ready` returns to 1 in the cycle after CRC_H is accepted. No back-to-back acceptance occurs in the same cycle as the CRC_H transfer.
- Reset asserted mid-packet: the framer aborts immediately and emits no further bytes. The truncated packet is left for the bus timeout.
- `cmd_len` 5..7 on WRITE: clamped to 4. `cmd_len`=0 on WRITE: only the address is sent (LEN=5).

## Configuration
- `DXL_BYTE_STUFFING_EN` defined:
  - During LOAD, any FF FF FD sequence inside INST+params gets an extra FD inserted after it.
  - LEN and CRC include the inserted bytes.
  - The payload buffer is 9 bytes (7 max raw + 2 stuffed).
- Undefined: no stuffing, 7-byte buffer. A packet containing FF FF FD in params is sent raw and is the caller's responsibility.

## Structure
- Package `dxl_pkg` holds:
  - instruction code constants
  - header constants (0xFF, 0xFD, 0x00)
  - CRC polynomial 0x8005
  - state enum typedef
  - max payload length constants for both configurations
- Sub-module `dxl_crc16`: byte-wide CRC update (8 unrolled steps) with synchronous clear in LOAD and enable on accepted byte. It shares `clock`/`reset`.

## Test plan
- PING id 1, `tx_ready`=1 → FF FF FD 00 01 03 00 01 19 4E; `tx_last` only on 4E; `cmd_ready` back high 11 cycles after accept.
- WRITE id 1, addr 116, data 512, len 4 → FF FF FD 00 01 09 00 03 74 00 00 02 00 00 CA 89.
- READ id 1, addr 132, len 4 → FF FF FD 00 01 07 00 02 84 00 04 00 1D 15.
- WRITE id 0, addr 30, data 1023, len 2, random `tx_ready` stalls → byte stream identical to the stall-free run; `tx_data` stable during every stall; CRC matches the software reference model.
- Reset pulsed after the 6th byte, then PING id 1 → no bytes after the abort; the new packet is correct from the first FF.
- With `DXL_BYTE_STUFFING_EN`: WRITE addr 0xFFFF, data 0xFD, len 1 → params FF FF FD FD; LEN=0x07.
- With `DXL_BYTE_STUFFING_EN` off, same command → params FF FF FD; LEN=0x06.

Source files
------------

// File: rtl/dxl_pkg.sv
// Shared constants, types and the CRC-16 helper for the Dynamixel 2.0 packet framer.
// The payload buffer depth follows DXL_BYTE_STUFFING_EN (9 bytes with stuffing, 7 without).
package dxl_pkg;

    localparam logic [7:0] INST_PING      = 8'h01;
    localparam logic [7:0] INST_READ      = 8'h02;
    localparam logic [7:0] INST_WRITE     = 8'h03;
    localparam logic [7:0] INST_REG_WRITE = 8'h04;
    localparam logic [7:0] INST_ACTION    = 8'h05;
    localparam logic [7:0] INST_REBOOT    = 8'h08;

    localparam logic [7:0] HDR_FF  = 8'hFF;
    localparam logic [7:0] HDR_FD  = 8'hFD;
    localparam logic [7:0] HDR_RSV = 8'h00;

    localparam logic [15:0] CRC_POLY = 16'h8005;

    localparam int PAY_MAX_RAW     = 7;
    localparam int PAY_MAX_STUFFED = 9;
`ifdef DXL_BYTE_STUFFING_EN
    localparam int PAY_MAX = PAY_MAX_STUFFED;
`else
    localparam int PAY_MAX = PAY_MAX_RAW;
`endif

    typedef logic [3:0] dxl_state_t;
    localparam dxl_state_t ST_IDLE    = 4'd0;
    localparam dxl_state_t ST_LOAD    = 4'd1;
    localparam dxl_state_t ST_HDR     = 4'd2;
    localparam dxl_state_t ST_ID      = 4'd3;
    localparam dxl_state_t ST_LEN_L   = 4'd4;
    localparam dxl_state_t ST_LEN_H   = 4'd5;
    localparam dxl_state_t ST_PAYLOAD = 4'd6;
    localparam dxl_state_t ST_CRC_L   = 4'd7;
    localparam dxl_state_t ST_CRC_H   = 4'd8;

    typedef struct packed {
        logic [7:0]  id;
        logic [7:0]  inst;
        logic [15:0] addr;
        logic [31:0] data;
        logic [2:0]  len;
    } dxl_cmd_t;

    // MSB-first CRC-16/0x8005 over one byte, no reflection
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else       c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/dxl_crc16.sv
// Byte-wide CRC-16 accumulator: cleared while a packet loads, advanced on each accepted byte.
module dxl_crc16
    import dxl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [15:0] crc,
    output logic [15:0] crc_next
);

    logic [15:0] crc_r;

    assign crc_next = crc16_byte(crc_r, data);
    assign crc      = crc_r;

    // Accumulator register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      crc_r <= 16'h0000;
        else if (clear)  crc_r <= 16'h0000;
        else if (enable) crc_r <= crc_next;
        else             crc_r <= crc_r;
    end

endmodule

// File: rtl/dxl_packet_framer.sv
// Frames one decoded command into a Dynamixel 2.0 instruction packet, streamed byte by byte.
// Define DXL_BYTE_STUFFING_EN to insert FD after any FF FF FD inside INST+params.
module dxl_packet_framer
    import dxl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_id,
    input  logic [7:0]  cmd_inst,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [2:0]  cmd_len,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy
);

    dxl_state_t state_r, state_nxt_s;
    logic [3:0] idx_r, idx_nxt_s;
    dxl_cmd_t   cmd_r;
    logic [7:0] pay_r [PAY_MAX];
    logic [3:0] pay_cnt_r;
    logic [7:0] len_r;
    logic [7:0] tx_data_r, data_nxt_s;
    logic       tx_valid_r, valid_nxt_s, tx_last_r, last_nxt_s;
    logic       cmd_ready_r, busy_r;
    logic       accept_s, xfer_s, crc_en_s;
    logic [15:0] crc_s, crc_nxt_s, crc_sel_s;
    logic [7:0] raw_s [PAY_MAX_RAW];
    logic [3:0] raw_cnt_s;
    logic [2:0] dlen_s;
    logic [7:0] buf_s [PAY_MAX];
    logic [3:0] buf_cnt_s;

    assign accept_s  = cmd_valid && cmd_ready_r;
    assign xfer_s    = tx_valid_r && tx_ready;
    assign crc_en_s  = xfer_s && (state_r inside {ST_HDR, ST_ID, ST_LEN_L, ST_LEN_H, ST_PAYLOAD});
    // The last param's CRC contribution lands on the same edge that loads CRC_L
    assign crc_sel_s = (state_r == ST_PAYLOAD) ? crc_nxt_s : crc_s;

    assign cmd_ready = cmd_ready_r;
    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign tx_last   = tx_last_r;
    assign busy      = busy_r;

    dxl_crc16 u_crc (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_r == ST_LOAD),
        .enable   (crc_en_s),
        .data     (tx_data_r),
        .crc      (crc_s),
        .crc_next (crc_nxt_s)
    );

    // Raw INST+params from the latched command
    always_comb begin
        for (int i = 0; i < PAY_MAX_RAW; i++) raw_s[i] = 8'h00;
        dlen_s    = (cmd_r.len > 3'd4) ? 3'd4 : cmd_r.len;
        raw_s[0]  = cmd_r.inst;
        raw_cnt_s = 4'd1;
        case (cmd_r.inst)
            INST_WRITE, INST_REG_WRITE: begin
                raw_s[1]  = cmd_r.addr[7:0];
                raw_s[2]  = cmd_r.addr[15:8];
                raw_s[3]  = cmd_r.data[7:0];
                raw_s[4]  = cmd_r.data[15:8];
                raw_s[5]  = cmd_r.data[23:16];
                raw_s[6]  = cmd_r.data[31:24];
                raw_cnt_s = 4'd3 + {1'b0, dlen_s};
            end
            INST_READ: begin
                raw_s[1]  = cmd_r.addr[7:0];
                raw_s[2]  = cmd_r.addr[15:8];
                raw_s[3]  = {5'b00000, cmd_r.len};
                raw_s[4]  = 8'h00;
                raw_cnt_s = 4'd5;
            end
            default: raw_cnt_s = 4'd1;
        endcase
    end

`ifdef DXL_BYTE_STUFFING_EN
    // Copy raw bytes, inserting FD after each FF FF FD run
    always_comb begin
        for (int i = 0; i < PAY_MAX; i++) buf_s[i] = 8'h00;
        buf_cnt_s = 4'd0;
        for (int i = 0; i < PAY_MAX_RAW; i++) begin
            if (i < int'(raw_cnt_s)) begin
                buf_s[buf_cnt_s] = raw_s[i];
                buf_cnt_s = buf_cnt_s + 4'd1;
                if (buf_cnt_s >= 4'd3 && buf_s[buf_cnt_s - 4'd1] == HDR_FD &&
                    buf_s[buf_cnt_s - 4'd2] == HDR_FF && buf_s[buf_cnt_s - 4'd3] == HDR_FF) begin
                    buf_s[buf_cnt_s] = HDR_FD;
                    buf_cnt_s = buf_cnt_s + 4'd1;
                end else begin
                    buf_cnt_s = buf_cnt_s;
                end
            end else begin
                buf_cnt_s = buf_cnt_s;
            end
        end
    end
`else
    // Raw bytes go out unchanged
    always_comb begin
        for (int i = 0; i < PAY_MAX; i++) buf_s[i] = raw_s[i];
        buf_cnt_s = raw_cnt_s;
    end
`endif

    // Sequencer: next state, index and the byte to present after each edge
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        data_nxt_s  = tx_data_r;
        valid_nxt_s = tx_valid_r;
        last_nxt_s  = tx_last_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_LOAD;
                else          state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                state_nxt_s = ST_HDR;
                idx_nxt_s   = 4'd0;
                data_nxt_s  = HDR_FF;
                valid_nxt_s = 1'b1;
                last_nxt_s  = 1'b0;
            end
            ST_HDR: begin
                if (xfer_s && idx_r == 4'd3) begin
                    state_nxt_s = ST_ID;
                    idx_nxt_s   = 4'd0;
                    data_nxt_s  = cmd_r.id;
                end else if (xfer_s) begin
                    idx_nxt_s  = idx_r + 4'd1;
                    data_nxt_s = (idx_r == 4'd1) ? HDR_FD : ((idx_r == 4'd2) ? HDR_RSV : HDR_FF);
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            ST_ID: begin
                if (xfer_s) begin state_nxt_s = ST_LEN_L; data_nxt_s = len_r; end
                else        state_nxt_s = ST_ID;
            end
            ST_LEN_L: begin
                if (xfer_s) begin state_nxt_s = ST_LEN_H; data_nxt_s = 8'h00; end
                else        state_nxt_s = ST_LEN_L;
            end
            ST_LEN_H: begin
                if (xfer_s) begin
                    state_nxt_s = ST_PAYLOAD;
                    idx_nxt_s   = 4'd0;
                    data_nxt_s  = pay_r[0];
                end else begin
                    state_nxt_s = ST_LEN_H;
                end
            end
            ST_PAYLOAD: begin
                if (xfer_s && idx_r == pay_cnt_r - 4'd1) begin
                    state_nxt_s = ST_CRC_L;
                    data_nxt_s  = crc_sel_s[7:0];
                end else if (xfer_s) begin
                    idx_nxt_s  = idx_r + 4'd1;
                    data_nxt_s = pay_r[idx_r + 4'd1];
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            ST_CRC_L: begin
                if (xfer_s) begin
                    state_nxt_s = ST_CRC_H;
                    data_nxt_s  = crc_sel_s[15:8];
                    last_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_CRC_L;
                end
            end
            ST_CRC_H: begin
                if (xfer_s) begin
                    state_nxt_s = ST_IDLE;
                    data_nxt_s  = 8'h00;
                    valid_nxt_s = 1'b0;
                    last_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_CRC_H;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                data_nxt_s  = 8'h00;
                valid_nxt_s = 1'b0;
                last_nxt_s  = 1'b0;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= 4'd0;
            tx_data_r   <= 8'h00;
            tx_valid_r  <= 1'b0;
            tx_last_r   <= 1'b0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            tx_data_r   <= data_nxt_s;
            tx_valid_r  <= valid_nxt_s;
            tx_last_r   <= last_nxt_s;
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Command latch on accept, payload buffer and LEN in LOAD
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_r     <= '0;
            pay_cnt_r <= 4'd0;
            len_r     <= 8'h00;
            for (int i = 0; i < PAY_MAX; i++) pay_r[i] <= 8'h00;
        end else begin
            if (accept_s) cmd_r <= '{id: cmd_id, inst: cmd_inst, addr: cmd_addr, data: cmd_data, len: cmd_len};
            if (state_r == ST_LOAD) begin
                for (int i = 0; i < PAY_MAX; i++) pay_r[i] <= buf_s[i];
                pay_cnt_r <= buf_cnt_s;
                len_r     <= {4'h0, buf_cnt_s} + 8'd2;
            end
        end
    end

endmodule
